ram_sdp_param: RTL and testbench

Parametrised simple-dual-port RAM with independent read and write addresses. It adds a selectable read-during-write mode, a read-valid flag, and a hardware clear engine that zeroes the array after reset or on request. It is the storage primitive for buffers and lookup tables across the design, with one write port and one read port in one clock domain.

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_sdp_core.sv | 47 ++++
 rtl/ram_sdp_param.sv | 117 +++++++++++
 tb/tb_ram_sdp_param.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the simple-dual-port RAM family.
// Holds the clear-engine state type, read-during-write policy codes and the depth helper.
package ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } ram_state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   function automatic int depth(input int addr_w);
      return 2 ** addr_w;
   endfunction

endpackage

// File: rtl/ram_sdp_core.sv
// Bare simple-dual-port array: one write port, one registered read port with
// a same-address read-during-write mux selected by RDW_NEW.
module ram_sdp_core
   import ram_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 6,
   parameter int RDW_NEW = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   localparam int DEPTH = depth(ADDR_W);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              bypass;

   // Forward the incoming word only when the policy asks for new data.
   assign bypass = (RDW_NEW != RDW_OLD) && wr_en && (wr_addr == rd_addr);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= bypass ? wr_data : mem[rd_addr];
         end
      end
   end

endmodule

// File: rtl/ram_sdp_param.sv
// Simple-dual-port RAM with a clear engine that zeroes the array after reset or on clr.
// Define RAM_OUT_REG_EN to add an output register stage (read latency 2).
module ram_sdp_param
   import ram_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 6,
   parameter int RDW_NEW = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] data,
   input  logic              re,
   input  logic [ADDR_W-1:0] read_addr,
   input  logic              clr,
   output logic [DATA_W-1:0] q,
   output logic              rd_valid,
   output logic              busy,
   output ram_state_t        state
);

   localparam int DEPTH = depth(ADDR_W);
   localparam logic [ADDR_W:0] CNT_END = DEPTH[ADDR_W:0];

   ram_state_t        state_next;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_next;
   logic              clearing;
   logic              running;
   logic              core_we;
   logic [ADDR_W-1:0] core_wa;
   logic [DATA_W-1:0] core_wd;
   logic              core_re;
   logic [DATA_W-1:0] core_q;
   logic              core_v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // The extra counter bit makes "just wrote DEPTH-1" an exact match on DEPTH.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_CLEAR: begin
            cnt_next = cnt + 1'b1;
            if (cnt_next == CNT_END) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (clr) begin
               state_next = ST_CLEAR;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = ST_CLEAR;
            cnt_next   = '0;
         end
      endcase
   end

   assign clearing = (state == ST_CLEAR);
   assign running  = (state == ST_RUN);
   assign busy     = clearing;

   // clr takes priority over any access sampled in the same cycle.
   assign core_we = clearing | (running & we & ~clr);
   assign core_wa = clearing ? cnt[ADDR_W-1:0] : write_addr;
   assign core_wd = clearing ? '0 : data;
   assign core_re = running & re & ~clr;

   ram_sdp_core #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .RDW_NEW (RDW_NEW)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (core_we),
      .wr_addr  (core_wa),
      .wr_data  (core_wd),
      .rd_en    (core_re),
      .rd_addr  (read_addr),
      .rd_data  (core_q),
      .rd_valid (core_v)
   );

`ifdef RAM_OUT_REG_EN
   // Not flushed by clr: a read already in the core finishes here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q        <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= core_v;
         if (core_v) begin
            q <= core_q;
         end
      end
   end
`else
   assign q        = core_q;
   assign rd_valid = core_v;
`endif

endmodule

// File: tb/tb_ram_sdp_param.sv
// Bench for ram_sdp_param: one instance per read-during-write policy, a spec-level
// model checked every cycle, and directed scenarios with literal expectations.
module tb_ram_sdp_param;
   import ram_pkg::*;

   localparam int DW    = 8;
   localparam int AW    = 6;
   localparam int DEPTH = 64;
`ifdef RAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   // ---------------- clock / reset / stimulus signals ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          we  = 1'b0;
   logic          re  = 1'b0;
   logic          clr = 1'b0;
   logic [AW-1:0] wa  = '0;
   logic [AW-1:0] ra  = '0;
   logic [DW-1:0] d   = '0;

   logic [DW-1:0] q_n, q_o;
   logic          v_n, v_o, busy_n, busy_o;
   ram_state_t    state_n, state_o;

   always #5 clk = ~clk;

   ram_sdp_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_NEW(1)) dut_new (
      .clk(clk), .rst(rst), .we(we), .write_addr(wa), .data(d), .re(re),
      .read_addr(ra), .clr(clr), .q(q_n), .rd_valid(v_n), .busy(busy_n), .state(state_n)
   );

   ram_sdp_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_NEW(0)) dut_old (
      .clk(clk), .rst(rst), .we(we), .write_addr(wa), .data(d), .re(re),
      .read_addr(ra), .clr(clr), .q(q_o), .rd_valid(v_o), .busy(busy_o), .state(state_o)
   );

   // ---------------- scoreboard counters ----------------
   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_mem [DEPTH];
   int            clear_left = DEPTH;
   bit            p_v  [LAT];
   logic [DW-1:0] p_dn [LAT];
   logic [DW-1:0] p_do [LAT];
   logic [DW-1:0] e_qn = '0;
   logic [DW-1:0] e_qo = '0;
   bit            e_v  = 1'b0;
   bit            s_v;
   logic [DW-1:0] s_n, s_o;

   initial begin
      for (int i = 0; i < LAT; i++) begin
         p_v[i] = 1'b0; p_dn[i] = '0; p_do[i] = '0;
      end
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            clear_left = DEPTH;
            for (int i = 0; i < LAT; i++) begin
               p_v[i] = 1'b0; p_dn[i] = '0; p_do[i] = '0;
            end
            e_qn = '0; e_qo = '0; e_v = 1'b0;
         end else begin
            s_v = 1'b0; s_n = '0; s_o = '0;
            if (clear_left > 0) begin
               m_mem[AW'(DEPTH - clear_left)] = '0;
               clear_left--;
            end else if (clr) begin
               clear_left = DEPTH;
            end else begin
               if (re) begin
                  s_v = 1'b1;
                  s_o = m_mem[ra];
                  s_n = (we && wa == ra) ? d : s_o;
               end
               if (we) m_mem[wa] = d;
            end
            for (int i = LAT - 1; i > 0; i--) begin
               p_v[i] = p_v[i-1]; p_dn[i] = p_dn[i-1]; p_do[i] = p_do[i-1];
            end
            p_v[0] = s_v; p_dn[0] = s_n; p_do[0] = s_o;
            e_v = p_v[LAT-1];
            if (e_v) begin
               e_qn = p_dn[LAT-1];
               e_qo = p_do[LAT-1];
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en  = 1'b0;
   int vld_cnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (v_n) vld_cnt++;
         if (cmp_en) begin
            check("busy_new",  32'(busy_n),  32'(clear_left != 0));
            check("busy_old",  32'(busy_o),  32'(clear_left != 0));
            check("state_new", 32'(state_n), 32'((clear_left != 0) ? ST_CLEAR : ST_RUN));
            check("valid_new", 32'(v_n),     32'(e_v));
            check("valid_old", 32'(v_o),     32'(e_v));
            check("q_new",     32'(q_n),     32'(e_qn));
            check("q_old",     32'(q_o),     32'(e_qo));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input bit w, input logic [AW-1:0] a_w, input logic [DW-1:0] dd,
                        input bit r, input logic [AW-1:0] a_r, input bit c);
      we = w; wa = a_w; d = dd; re = r; ra = a_r; clr = c;
   endtask

   task automatic cyc(input bit w, input logic [AW-1:0] a_w, input logic [DW-1:0] dd,
                      input bit r, input logic [AW-1:0] a_r, input bit c);
      @(negedge clk);
      #1;
      drive(w, a_w, dd, r, a_r, c);
   endtask

   task automatic idle();
      cyc(1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic drive_junk();
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), 8'hEE,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
            1'($urandom_range(0, 1)));
   endtask

   // Counts clock edges with busy high; call just before the first clear edge.
   task automatic run_clear(input bit junk, output int n);
      n = 0;
      while (n < 200) begin
         if (!busy_n) break;
         if (junk) drive_junk();
         else drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
         n++;
         @(negedge clk);
         #1;
      end
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   // Issue one read (optionally with a write) and check the literal result at its latency.
   task automatic rd_lit(input string name, input bit w, input logic [AW-1:0] a_w,
                         input logic [DW-1:0] dd, input logic [AW-1:0] a,
                         input logic [DW-1:0] en, input logic [DW-1:0] eo);
      cyc(w, a_w, dd, 1'b1, a, 1'b0);
      idle();
      repeat (LAT - 1) begin
         @(posedge clk);
         #1;
      end
      check({name, "_q_new"}, 32'(q_n), 32'(en));
      check({name, "_q_old"}, 32'(q_o), 32'(eo));
      check({name, "_valid"}, 32'(v_n), 32'd1);
   endtask

   // ---------------- directed scenarios ----------------
   int n;
   int v0;

   initial begin
      #1;
      rst    = 1'b1;
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy",  32'(busy_n),  32'd1);
      check("rst_valid", 32'(v_n),     32'd0);
      check("rst_q",     32'(q_n),     32'd0);
      check("rst_state", 32'(state_n), 32'(ST_CLEAR));
      #1;
      rst = 1'b0;

      run_clear(1'b0, n);
      check("clear_len_boot", 32'(n), 32'd64);

      // First access is accepted in the very cycle busy is seen low.
      drive(1'b1, 6'd10, 8'h3C, 1'b0, '0, 1'b0);
      rd_lit("first_access", 1'b0, '0, '0, 6'd10, 8'h3C, 8'h3C);

      v0 = vld_cnt;
      for (int a = 0; a < DEPTH; a++) begin
         if (a != 10) cyc(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
      end
      repeat (4) idle();
      check("read_all_pulses", 32'(vld_cnt - v0), 32'd63);

      cyc(1'b1, 6'd5, 8'hA5, 1'b0, '0, 1'b0);
      rd_lit("rd5", 1'b0, '0, '0, 6'd5, 8'hA5, 8'hA5);

      cyc(1'b1, 6'd9, 8'h11, 1'b0, '0, 1'b0);
      rd_lit("rdw9", 1'b1, 6'd9, 8'h22, 6'd9, 8'h22, 8'h11);
      rd_lit("after_rdw9", 1'b0, '0, '0, 6'd9, 8'h22, 8'h22);

      for (int i = 0; i < 4; i++) cyc(1'b1, AW'(i), DW'(8'h30 + i), 1'b0, '0, 1'b0);
      idle();
      v0 = vld_cnt;
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1, AW'(i), 1'b0);
      repeat (4) idle();
      check("burst_pulses", 32'(vld_cnt - v0), 32'd4);

      for (int i = 0; i < 60; i++) begin
         cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), 1'b0);
      end
      idle();

      cyc(1'b1, 6'd3, 8'h44, 1'b0, '0, 1'b0);
      cyc(1'b1, 6'd3, 8'h7F, 1'b1, 6'd3, 1'b1);
      idle();
      run_clear(1'b0, n);
      check("clear_len_clr", 32'(n), 32'd64);
      rd_lit("addr3_cleared", 1'b0, '0, '0, 6'd3, 8'h00, 8'h00);

      cyc(1'b1, 6'd40, 8'h99, 1'b0, '0, 1'b1);
      idle();
      repeat (20) begin
         @(negedge clk);
         #1;
         drive_junk();
      end
      rst = 1'b1;
      @(negedge clk);
      check("midclr_busy",  32'(busy_n), 32'd1);
      check("midclr_valid", 32'(v_n),    32'd0);
      check("midclr_q",     32'(q_n),    32'd0);
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      run_clear(1'b1, n);
      check("clear_len_midrst", 32'(n), 32'd64);
      rd_lit("addr40_cleared", 1'b0, '0, '0, 6'd40, 8'h00, 8'h00);

      cyc(1'b1, 6'd7, 8'h5A, 1'b0, '0, 1'b0);
      cyc(1'b0, '0, '0, 1'b1, 6'd7, 1'b0);
      @(negedge clk);
      #1;
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("midrd_valid", 32'(v_n), 32'd0);
      check("midrd_q",     32'(q_n), 32'd0);
      #1;
      rst = 1'b0;
      run_clear(1'b0, n);
      check("clear_len_midrd", 32'(n), 32'd64);
      rd_lit("addr7_cleared", 1'b0, '0, '0, 6'd7, 8'h00, 8'h00);

      repeat (3) idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #300000;
      n_fail++;
      $display("FAIL timeout: simulation did not finish, got no end, expected end");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $fatal(1, "timeout");
   end

endmodule
